onehot_reg_bank: RTL

Register storage stage that sits directly downstream of the address decoder. The decoder turns a write-register index plus a write enable into a one-hot vector; this block uses that vector as per-register write strobes. It holds the architectural integer registers and serves two combinational read ports with write-through bypass. It also polices the one-hot contract: malformed strobe vectors are rejected and flagged.

---
 rtl/onehot_reg_bank.sv | 85 ++++++++
 1 files changed

// File: rtl/onehot_reg_bank.sv
// Register bank written through one-hot strobes from the address decoder, with two
// combinational read ports, write-through bypass and one-hot contract policing.
module onehot_reg_bank #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**ADDR_W-1:0]  wr_sel,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [ADDR_W-1:0]     rs1_addr,
    input  logic [ADDR_W-1:0]     rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  err_sticky,
    output logic [15:0]           wr_count
);

    localparam int unsigned NREGS = 2**ADDR_W;

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_ack_q, wr_err_q, err_sticky_q;
    logic [15:0]     wr_count_q;

    logic is_zero, is_onehot, is_multi;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    always_comb begin
        is_zero   = (wr_sel == '0);
        is_onehot = !is_zero && ((wr_sel & (wr_sel - 1'b1)) == '0);
        is_multi  = !is_zero && !is_onehot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_ack_q     <= 1'b0;
            wr_err_q     <= 1'b0;
            err_sticky_q <= 1'b0;
            wr_count_q   <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (is_onehot && wr_sel[i] && !(i == 0 && ZERO_REG != 0)) begin
                    regs_q[i] <= wr_data;
                end
            end
            wr_ack_q     <= is_onehot;
            wr_err_q     <= is_multi;
            err_sticky_q <= err_sticky_q | is_multi;
            // A discarded write to the zero register still counts as accepted.
            if (is_onehot) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (is_onehot && wr_sel[rs1_addr]) begin
            rs1_data = wr_data;
        end
        if (ZERO_REG != 0 && rs1_addr == '0) begin
            rs1_data = '0;
        end

        rs2_data = regs_q[rs2_addr];
        if (is_onehot && wr_sel[rs2_addr]) begin
            rs2_data = wr_data;
        end
        if (ZERO_REG != 0 && rs2_addr == '0) begin
            rs2_data = '0;
        end
    end

    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign err_sticky = err_sticky_q;
    assign wr_count   = wr_count_q;

endmodule
